instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/instr_pack.sv | 60 ++++++
 rtl/instr_encoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction format codes, base opcodes and
// a signed range helper used by the immediate checker.
package riscv_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   function automatic logic in_range(input logic signed [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for R/I/S/B/U/J words. Format codes 6/7 are errors.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_pack
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt_i,
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        err_o
);

   fmt_e fmt;
   logic fmt_err;
   logic range_err;

   assign fmt = fmt_e'(fmt_i);

   always_comb begin
      word_o  = '0;
      fmt_err = 1'b0;
      case (fmt)
         FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         default: fmt_err = 1'b1;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   logic signed [31:0] imm_s;
   assign imm_s = imm_i;

   // Branch/jump offsets must be even since bit 0 is not encoded.
   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_I, FMT_S: range_err = !in_range(imm_s, -32'sd2048, 32'sd2047);
         FMT_B: range_err = !in_range(imm_s, -32'sd4096, 32'sd4094) || imm_i[0];
         FMT_J: range_err = !in_range(imm_s, -32'sd1048576, 32'sd1048574) || imm_i[0];
         FMT_U: range_err = (imm_i[11:0] != 12'd0);
         default: range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   assign err_o = fmt_err || range_err;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, emits packed words with addresses
// through a one-entry output register. IMM_RANGE_CHECK_EN enables immediate checks.
module instr_encoder
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  req_fmt_i,
   input  logic [6:0]  req_opcode_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [6:0]  req_funct7_i,
   input  logic [4:0]  req_rd_i,
   input  logic [4:0]  req_rs1_i,
   input  logic [4:0]  req_rs2_i,
   input  logic [31:0] req_imm_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_wdata_o,
   output logic [31:0] instr_addr_o,
   output logic        err_o,
   output logic [7:0]  err_cnt_o,
   input  logic        clear_i
);

   logic        valid_q, valid_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [31:0] pack_word;
   logic        pack_err;
   logic        accept;
   logic        out_hs;

   instr_pack u_pack (
      .fmt_i    (req_fmt_i),
      .opcode_i (req_opcode_i),
      .funct3_i (req_funct3_i),
      .funct7_i (req_funct7_i),
      .rd_i     (req_rd_i),
      .rs1_i    (req_rs1_i),
      .rs2_i    (req_rs2_i),
      .imm_i    (req_imm_i),
      .word_o   (pack_word),
      .err_o    (pack_err)
   );

   // Valid/ready: a transfer occurs on a rising clk_i edge where valid and ready
   // are both high; valid holds and its payload stays stable until that edge.
   // The request side is ready whenever the output register is empty or draining.
   assign req_ready_o = !valid_q || instr_ready_i;
   assign accept      = req_valid_i && req_ready_o;
   assign out_hs      = valid_q && instr_ready_i;

   always_comb begin
      valid_d = valid_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      if (out_hs) begin
         valid_d = 1'b0;
         addr_d  = addr_q + 32'd4;
      end
      if (accept && !pack_err) begin
         valid_d = 1'b1;
         wdata_d = pack_word;
      end

      // A new error on the clear cycle counts as the first error after clearing.
      if (clear_i) begin
         err_d = 1'b0;
         cnt_d = 8'd0;
      end
      if (accept && pack_err) begin
         err_d = 1'b1;
         if (clear_i)
            cnt_d = 8'd1;
         else if (cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         wdata_q <= '0;
         addr_q  <= BASE_ADDR;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         valid_q <= valid_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_valid_o = valid_q;
   assign instr_wdata_o = wdata_q;
   assign instr_addr_o  = addr_q;
   assign err_o         = err_q;
   assign err_cnt_o     = cnt_q;

endmodule
